serial_add_ctrl: RTL and testbench

- Sequencing controller for a single shared 1-bit full adder (s = a^b^cin, co = majority(a,b,cin)), used bit-serially to perform WIDTH-bit add/subtract, LSB first.
- Owns the operand shift registers, the carry flip-flop, the bit counter and a valid/ready handshake on both the input and output sides.
- Sits between an operand producer and a result consumer wherever area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract controller around one shared 1-bit full adder.
// Operands shift right LSB first; sum bits enter the result register from the MSB side.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             fa_s, fa_co;

    // Shared 1-bit full adder on the operand LSBs and the carry flop.
    always_comb begin
        fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
        fa_co = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cmsb_d      = cmsb_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    cnt_d   = '0;
                    cmsb_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                // The carry produced by bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_MSB_IN) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_co;
                    ovf_d   = cmsb_q ^ fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cmsb_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cmsb_q      <= cmsb_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output decode: ready is a pure function of state, the rest are flops.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        sum       = res_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH = 8.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests  = 0;
    int failed = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic and signed range check.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] rs, output logic rc, output logic ro);
        logic [7:0] nb;
        int unsigned full;
        int sa, sb, r;
        nb   = s ? ~b : b;
        full = 32'(a) + 32'(nb) + 32'(s);
        rs   = full[7:0];
        rc   = full[8];
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        r    = s ? (sa - sb) : (sa + sb);
        ro   = (r > 127) || (r < -128);
    endtask

    // Accept one operation, wait (bounded) for the result; optionally consume it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic early, input logic consume, input logic toggle,
                          output logic [7:0] rs, output logic rc, output logic ro,
                          output int lat);
        @(negedge clk);
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (early) out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (toggle) begin op_a = ~op_a; op_b = ~op_b; end
            else begin op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); end
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("idle_after_consume", {30'd0, in_ready, out_valid}, 32'b10);
        end
    endtask

    vec_t        tbl [5];
    logic [7:0]  rs, hs, ms;
    logic        rc, ro, hc, ho, mc, mo;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

        // Reset state while rst_n is low.
        #3;
        chk("reset_state", {20'd0, in_ready, out_valid, sum, cout, ovf}, {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        #9 rst_n = 1'b1;

        // Directed vectors, including latency.
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, 1'b0, 1'b1, 1'b0, rs, rc, ro, lat);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(tbl[i].es));
            chk($sformatf("vec%0d_flags", i), {30'd0, rc, ro}, {30'd0, tbl[i].ec, tbl[i].eo});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
        end

        // Backpressure: hold DONE for 5 cycles with a competing request.
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
            @(posedge clk); #1;
            chk("bp_hold", {21'd0, in_ready, out_valid, sum, cout, ovf}, {21'd0, 1'b0, 1'b1, 8'h8D, 1'b0, 1'b1});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // Operands toggled every cycle during RUN must not disturb the result.
        run_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, rs, rc, ro, lat);
        chk("toggle_result", {22'd0, rs, rc, ro}, {22'd0, 8'hFF, 1'b0, 1'b0});

        // out_ready held high from RUN onward has no early effect.
        run_op(8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, rs, rc, ro, lat);
        chk("early_ready", {14'd0, rs, 8'(lat), rc, ro}, {14'd0, 8'h46, 8'(W), 1'b0, 1'b0});

        // Reset asserted mid-cycle in RUN cycle 3 aborts immediately.
        @(negedge clk);
        op_a = 8'hC3; op_b = 8'h3C; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, in_ready, out_valid, sum, cout, ovf}, {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, rs, rc, ro, lat);
        chk("post_reset_add", {22'd0, rs, rc, ro}, {22'd0, 8'h02, 1'b0, 1'b0});

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            hs = 8'($urandom); ms = 8'($urandom); hc = 1'($urandom); ho = 1'($urandom_range(0, 3) == 0);
            run_op(hs, ms, hc, ho, 1'b1, 1'b0, rs, rc, ro, lat);
            model(hs, ms, hc, hs, mc, mo);
            chk($sformatf("rand%0d", i), {21'd0, rs, rc, ro, 1'b0}, {21'd0, hs, mc, mo, 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
